// File: rtl/ctrl_del_fsm.sv
// Delete responder: scans the key/valid store and invalidates the first valid entry that matches key_q.
// Optional feature macro CTRL_DEL_ABORT_EN adds abort_i, which cancels an in-flight scan.
module ctrl_del_fsm #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 16,
  localparam int AW         = $clog2(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CTRL_DEL_ABORT_EN
  input  logic                 abort_i,
`endif
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic [1:0]           result_o,
  output logic [1:0]           state_o,
  output logic                 busy_o,
  output logic                 mem_rd_en_o,
  output logic [AW-1:0]        mem_addr_o,
  input  logic [KEY_WIDTH-1:0] mem_key_i,
  input  logic                 mem_valid_i,
  output logic                 inv_en_o,
  output logic [AW-1:0]        inv_addr_o
);

  localparam logic [1:0] DEL_ST_START  = 2'd0;
  localparam logic [1:0] DEL_ST_DELETE = 2'd1;
  localparam logic [1:0] DEL_ST_ERROR  = 2'd2;

  localparam logic [AW:0]   NUM_PTR   = (AW+1)'(NUM_ENTRIES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ENTRIES - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [KEY_WIDTH-1:0] r_key_q;
  logic [AW:0]          r_rd_ptr;
  logic                 r_cmp_vld_p1;
  logic [AW-1:0]        r_cmp_addr_p1;
  logic                 r_done_p2;
  logic                 r_inv_en_p2;
  logic [AW-1:0]        r_inv_addr_p2;

  logic w_busy;
  logic w_accept;
  logic w_rd_en;
  logic w_hit;
  logic w_last;
  logic w_abort;

  assign w_busy   = (r_state == DEL_ST_DELETE) || (r_state == DEL_ST_ERROR);
  assign w_accept = (r_state == DEL_ST_START) && start_i;

`ifdef CTRL_DEL_ABORT_EN
  assign w_abort = abort_i && w_busy;
`else
  assign w_abort = 1'b0;
`endif

  // Stage p0: issue reads; rd_ptr carries an extra bit so it stops at NUM_ENTRIES instead of wrapping.
  assign w_rd_en = (r_state == DEL_ST_DELETE) && (r_rd_ptr < NUM_PTR);

  // Stage p1: store data for r_cmp_addr_p1 is on mem_key_i/mem_valid_i now.
  assign w_hit  = (r_state == DEL_ST_DELETE) && r_cmp_vld_p1 && mem_valid_i &&
                  (mem_key_i == r_key_q);
  assign w_last = (r_state == DEL_ST_DELETE) && r_cmp_vld_p1 &&
                  (r_cmp_addr_p1 == LAST_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DEL_ST_START: begin
        if (start_i) w_state_nxt = DEL_ST_DELETE;
      end
      DEL_ST_DELETE: begin
        if (w_abort)     w_state_nxt = DEL_ST_START;
        else if (w_hit)  w_state_nxt = DEL_ST_START;
        else if (w_last) w_state_nxt = DEL_ST_ERROR;
      end
      DEL_ST_ERROR: begin
        w_state_nxt = DEL_ST_START;
      end
      default: begin
        w_state_nxt = DEL_ST_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= DEL_ST_START;
      r_key_q       <= '0;
      r_rd_ptr      <= '0;
      r_cmp_vld_p1  <= 1'b0;
      r_cmp_addr_p1 <= '0;
      r_done_p2     <= 1'b0;
      r_inv_en_p2   <= 1'b0;
      r_inv_addr_p2 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_key_q  <= key_i;
        r_rd_ptr <= '0;
      end else if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // The speculative read in the hit cycle is never tagged valid, so its data is dropped.
      r_cmp_vld_p1  <= w_rd_en && (w_state_nxt == DEL_ST_DELETE);
      r_cmp_addr_p1 <= r_rd_ptr[AW-1:0];
      // Stage p2: registered done/invalidate, one cycle after the matching compare.
      r_done_p2     <= w_hit && !w_abort;
      r_inv_en_p2   <= w_hit && !w_abort;
      r_inv_addr_p2 <= (w_hit && !w_abort) ? r_cmp_addr_p1 : '0;
    end
  end

  assign result_o    = {r_done_p2, (r_state == DEL_ST_ERROR)};
  assign state_o     = r_state;
  assign busy_o      = w_busy;
  assign mem_rd_en_o = w_rd_en;
  assign mem_addr_o  = w_rd_en ? r_rd_ptr[AW-1:0] : '0;
  assign inv_en_o    = r_inv_en_p2;
  assign inv_addr_o  = r_inv_addr_p2;

endmodule

// File: tb/tb_ctrl_del_fsm.sv
// Bench for ctrl_del_fsm: emulated entry store plus a lowest-valid-match reference model with cycle-level timing expectations.
module tb_ctrl_del_fsm;
  localparam int N  = 8;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [KW-1:0] key_i;
  logic [1:0]    result_o;
  logic [1:0]    state_o;
  logic          busy_o;
  logic          mem_rd_en_o;
  logic [2:0]    mem_addr_o;
  logic [KW-1:0] mem_key_i   = '0;
  logic          mem_valid_i = 1'b0;
  logic          inv_en_o;
  logic [2:0]    inv_addr_o;
`ifdef CTRL_DEL_ABORT_EN
  logic          abort_i;
`endif

  ctrl_del_fsm #(.NUM_ENTRIES(N), .KEY_WIDTH(KW)) dut (
    .clk(clk), .rst(rst),
`ifdef CTRL_DEL_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .key_i(key_i),
    .result_o(result_o), .state_o(state_o), .busy_o(busy_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
    .mem_key_i(mem_key_i), .mem_valid_i(mem_valid_i),
    .inv_en_o(inv_en_o), .inv_addr_o(inv_addr_o)
  );

  always #5 clk = ~clk;

  // Entry store (s_*) as seen by the DUT, and the reference model's expected contents (m_*).
  logic [KW-1:0] s_key   [N];
  logic          s_valid [N];
  logic [KW-1:0] m_key   [N];
  logic          m_valid [N];

  always @(posedge clk) begin
    if (mem_rd_en_o) begin
      mem_key_i   <= s_key[mem_addr_o];
      mem_valid_i <= s_valid[mem_addr_o];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [KW-1:0] k, input logic v);
    s_key[i] = k; s_valid[i] = v;
    m_key[i] = k; m_valid[i] = v;
  endtask

  task automatic clear_store();
    for (int i = 0; i < N; i++) put(i, 16'hFFFF - 16'(i), 1'b0);
  endtask

  // Reference: lowest index holding a valid copy of key, or -1.
  function automatic int model_find(input logic [KW-1:0] key);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_key[i] == key) return i;
    return -1;
  endfunction

  // Advance one cycle; the store applies any invalidate the DUT presents.
  task automatic tick();
    @(posedge clk);
    #1;
    if (inv_en_o) s_valid[inv_addr_o] = 1'b0;
  endtask

  // Expected outputs k cycles after acceptance, for hit index h (or -1 = miss).
  task automatic check_cycle(input int k, input int h);
    bit         hit      = (h >= 0);
    int         busy_end = hit ? 2 + h : N + 2;
    int         rd_end   = hit ? ((2 + h < N) ? 2 + h : N) : N;
    logic       e_busy   = (k <= busy_end);
    logic       e_err    = !hit && (k == N + 2);
    logic       e_done   = hit && (k == 3 + h);
    logic       e_rd     = (k <= rd_end);
    logic [1:0] e_state  = e_err ? 2'd2 : (e_busy ? 2'd1 : 2'd0);
    chk($sformatf("busy k=%0d", k),  32'(busy_o),      32'(e_busy));
    chk($sformatf("state k=%0d", k), 32'(state_o),     32'(e_state));
    chk($sformatf("rd_en k=%0d", k), 32'(mem_rd_en_o), 32'(e_rd));
    if (e_rd) chk($sformatf("addr k=%0d", k), 32'(mem_addr_o), 32'(k - 1));
    chk($sformatf("done k=%0d", k),  32'(result_o[1]), 32'(e_done));
    chk($sformatf("error k=%0d", k), 32'(result_o[0]), 32'(e_err));
    chk($sformatf("inv_en k=%0d", k), 32'(inv_en_o),   32'(e_done));
    if (e_done) chk($sformatf("inv_addr k=%0d", k), 32'(inv_addr_o), 32'(h));
  endtask

  task automatic issue(input logic [KW-1:0] key);
    tick();
    chk("idle before start", 32'(state_o), 32'd0);
    start_i = 1'b1;
    key_i   = key;
  endtask

  // Follows one accepted request to completion; optionally fires a new start in the last cycle.
  task automatic scan(input logic [KW-1:0] key, input bit noise, input bit chain,
                      input logic [KW-1:0] key2);
    int h    = model_find(key);
    int last = (h >= 0) ? 3 + h : N + 3;
    if (h >= 0) m_valid[h] = 1'b0;
    for (int k = 1; k <= last; k++) begin
      tick();
      start_i = noise && (k <= 3);
      if (start_i) key_i = 16'($urandom);
      check_cycle(k, h);
      if (chain && k == last) begin
        start_i = 1'b1;
        key_i   = key2;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; key_i = '0;
`ifdef CTRL_DEL_ABORT_EN
    abort_i = 1'b0;
`endif
    clear_store();
    tick(); tick(); tick();
    chk("reset outputs", 32'({result_o, state_o, busy_o, mem_rd_en_o, mem_addr_o, inv_en_o, inv_addr_o}), 32'd0);
    rst = 1'b0;

    // Hit at entry 3
    for (int i = 0; i < N; i++) put(i, 16'h0300 + 16'(i), 1'b1);
    put(3, 16'h00A5, 1'b1);
    issue(16'h00A5); scan(16'h00A5, 1'b0, 1'b0, '0);

    // Miss
    issue(16'h1234); scan(16'h1234, 1'b0, 1'b0, '0);

    // Invalid copy at 2, valid at 5
    put(2, 16'h0042, 1'b0); put(5, 16'h0042, 1'b1);
    issue(16'h0042); scan(16'h0042, 1'b0, 1'b0, '0);

    // Duplicates at 1 and 6; back-to-back start in the done cycle finds the remaining copy
    put(1, 16'h0777, 1'b1); put(6, 16'h0777, 1'b1);
    issue(16'h0777); scan(16'h0777, 1'b0, 1'b1, 16'h0777);
    scan(16'h0777, 1'b0, 1'b0, '0);

    // Start pulses during a scan are ignored
    put(3, 16'h00A5, 1'b1);
    issue(16'h00A5); scan(16'h00A5, 1'b1, 1'b0, '0);

    // Reset mid-scan aborts silently; the entry remains valid for the next request
    put(3, 16'h0BEE, 1'b1);
    issue(16'h0BEE);
    for (int k = 1; k <= 3; k++) begin
      tick(); start_i = 1'b0;
      check_cycle(k, 3);
    end
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("outputs after mid-scan reset", 32'({result_o, state_o, busy_o, mem_rd_en_o, mem_addr_o, inv_en_o, inv_addr_o}), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("quiet after reset k=%0d", k), 32'({result_o, busy_o, inv_en_o}), 32'd0);
    end
    issue(16'h0BEE); scan(16'h0BEE, 1'b0, 1'b0, '0);

`ifdef CTRL_DEL_ABORT_EN
    put(3, 16'h0ABC, 1'b1);
    issue(16'h0ABC);
    for (int k = 1; k <= 4; k++) begin
      tick(); start_i = 1'b0;
      check_cycle(k, 3);
    end
    abort_i = 1'b1;
    tick(); abort_i = 1'b0;
    chk("abort state", 32'(state_o), 32'd0);
    chk("abort rd_en", 32'(mem_rd_en_o), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("quiet after abort k=%0d", k), 32'({result_o, inv_en_o}), 32'd0);
    end
`endif

    // Randomized stores and keys drawn from a small pool so duplicates and misses occur
    for (int it = 0; it < 25; it++) begin
      logic [KW-1:0] key;
      for (int i = 0; i < N; i++)
        put(i, 16'h0100 + 16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      key = 16'h0100 + 16'($urandom_range(0, 4));
      issue(key); scan(key, 1'b0, 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
